mii_rx_checker: RTL and testbench
=================================

Name: mii_rx_checker

Overview:
- Receive-side counterpart of the 64-bit MII frame generator.
- Parses a 64-bit data / 8-bit control stream: idle 0x07, start 0xFB, terminate 0xFD, error 0xFE.
- Strips start, preamble and SFD; emits frame bytes (DA through FCS) as 64-bit words with byte-keep, sof and eof; flags malformed frames.
- Sits between PCS decode output and the MAC/scoreboard in the verification bench; also usable as an RX MAC front end.

Parameters:
- PAYLOAD_MAX_SIZE, 1500: max payload bytes; max frame = PAYLOAD_MAX_SIZE+18 bytes.
- PAYLOAD_MIN_SIZE, 46: min payload bytes; min frame = PAYLOAD_MIN_SIZE+18 bytes.
- PREAMBLE_CHAR, 8'h55: expected preamble byte.
- SFD_CHAR, 8'hD5: expected SFD byte.

Ports:
- clk  in  1  clock
- i_rst_n  in  1  reset
- i_valid  in  1  input word qualifier
- i_mii_rx_d  in  64  data, lane0 = bits[7:0]
- i_mii_rx_c  in  8  control flag per lane
- o_data  out  64  frame bytes, lane0 first
- o_keep  out  8  valid lanes, contiguous from lane0
- o_valid  out  1  o_data/o_keep valid
- o_sof  out  1  first word of frame
- o_eof  out  1  last word of frame
- o_err  out  1  frame bad, valid with o_eof
- o_err_code  out  4  cause, valid with o_eof
- o_frame_len  out  16  byte count of frame, valid with o_eof
- o_frame_cnt  out  32  good frames received, saturating
- o_err_cnt  out  16  bad frames received, saturating

Behaviour:
- Reset (i_rst_n asynchronous, active-low; clock clk): all outputs 0, state IDLE, hold stage empty. Reset mid-frame discards the frame with no eof.
- i_valid=0: word ignored; state, counters and hold stage frozen; o_valid=0.
- Start accepted only in lane0: c[0]=1, d[7:0]=0xFB. Start in any other lane is ignored in IDLE.
- States:
  - IDLE: on start, check lanes1-6 == PREAMBLE_CHAR and lane7 == SFD_CHAR, all with c=0. Pass -> DATA, len=0. Fail -> DROP with err_code=1 (one eof+err word, keep=0).
  - DATA, no control lanes: 8 bytes forwarded, len+=8.
  - DATA, terminate in lane k (c[k]=1, d=0xFD, all lanes <k data): lanes <k forwarded, len+=k, eof, -> IDLE. Lanes >k not checked.
  - DATA, any other control char before terminate: err_code=2, eof+err, -> DROP.
  - DATA, start in lane0: err_code=6, current frame closed with eof+err; new start is not processed; -> DROP.
  - DROP: discard until a word containing terminate, or an all-idle word; then -> IDLE. No o_valid in DROP.
- Latency: one hold stage plus output register; word k appears on o_data 2 valid input cycles later.
  - Terminate in lane0: eof lands on the held previous word.
  - Frame with zero data bytes: one word, keep=0, sof=eof=1, err_code=3.
- At eof:
  - len < PAYLOAD_MIN_SIZE+18: err_code=3 (runt).
  - len exceeds PAYLOAD_MAX_SIZE+18 in DATA: abort immediately with err_code=4, eof+err on the current word, -> DROP.
- Error priority in one word: 6 > 2 > 4 > 3 > 5.
- len is 16-bit, saturates at 0xFFFF.
- o_frame_cnt increments on good eof, o_err_cnt on bad eof, one cycle after eof. Both saturate at all-ones.
- o_sof, o_eof, o_err are single-cycle pulses qualified by o_valid.

Optional Feature:
- MII_RX_CRC_CHECK_EN defined:
  - Running CRC-32 (IEEE 802.3, reflected, init 0xFFFFFFFF) over DA..FCS, 8 bytes/cycle, masked by keep.
  - Residue != 0xC704DD7B at eof -> err_code=5.
- Not defined: no CRC logic; err_code 5 never produced.

Test Plan:
- Good 64-byte frame: start word FB 55×6 D5, 8 data words, then FD 07×7 -> 8 o_valid words, keep=FF, sof on word1, eof on word8, len=64, o_err=0, o_frame_cnt=1.
- 67-byte frame, terminate in lane3 of final word -> last word keep=0x07, eof=1, len=67, err=0.
- Bad SFD 0xD4 -> single keep=0 eof word, err_code=1, o_err_cnt=1, next good frame accepted.
- 0xFE control in lane2 mid-frame -> eof+err, err_code=2; following data words dropped until FD.
- 40-byte frame -> err_code=3, len=40. A 1600-byte stream (MAX 1500) -> abort at byte 1519, err_code=4.
- i_valid toggled 0/1 every cycle during a 64-byte frame, plus reset asserted mid-frame -> identical output words, no eof after reset, all outputs 0, counters 0.

Source files
------------

// File: rtl/mii_rx_checker.sv
// mii_rx_checker: receive-side checker for a 64-bit MII stream (8 lanes, lane0 = bits[7:0]).
// Strips start/preamble/SFD and forwards frame bytes (DA..FCS) as 64-bit words with a
// contiguous byte-keep, sof and eof. Malformed frames are closed with eof+err and a cause code.
// Optional CRC-32 residue check is enabled by defining MII_RX_CRC_CHECK_EN.
//
// Ports:
//   clk, i_rst_n           clock, asynchronous active-low reset
//   i_valid                input word qualifier (0 = word ignored, everything frozen)
//   i_mii_rx_d/i_mii_rx_c  64-bit data, 8 per-lane control flags
//   o_data/o_keep/o_valid  frame bytes, valid lanes, qualifier
//   o_sof/o_eof            first/last word of a frame
//   o_err/o_err_code       bad frame and cause, valid with o_eof
//                          1 preamble/SFD, 2 stray control, 3 runt, 4 too long, 5 CRC, 6 restart
//   o_frame_len            frame byte count, valid with o_eof
//   o_frame_cnt/o_err_cnt  saturating good/bad frame counters
module mii_rx_checker #(
  parameter int unsigned PAYLOAD_MAX_SIZE = 1500,
  parameter int unsigned PAYLOAD_MIN_SIZE = 46,
  parameter logic [7:0]  PREAMBLE_CHAR    = 8'h55,
  parameter logic [7:0]  SFD_CHAR         = 8'hD5
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [63:0] i_mii_rx_d,
  input  logic [7:0]  i_mii_rx_c,
  output logic [63:0] o_data,
  output logic [7:0]  o_keep,
  output logic        o_valid,
  output logic        o_sof,
  output logic        o_eof,
  output logic        o_err,
  output logic [3:0]  o_err_code,
  output logic [15:0] o_frame_len,
  output logic [31:0] o_frame_cnt,
  output logic [15:0] o_err_cnt
);

  localparam logic [7:0]  CharIdle    = 8'h07;
  localparam logic [7:0]  CharStart   = 8'hFB;
  localparam logic [7:0]  CharTerm    = 8'hFD;
  localparam logic [15:0] MaxLen      = 16'(PAYLOAD_MAX_SIZE + 18);
  localparam logic [15:0] MinLen      = 16'(PAYLOAD_MIN_SIZE + 18);
  localparam logic [3:0]  ErrPreamble = 4'd1;
  localparam logic [3:0]  ErrCtrl     = 4'd2;
  localparam logic [3:0]  ErrRunt     = 4'd3;
  localparam logic [3:0]  ErrLong     = 4'd4;
  localparam logic [3:0]  ErrCrc      = 4'd5;
  localparam logic [3:0]  ErrStart    = 4'd6;

  typedef enum logic [1:0] {StIdle, StData, StDrop} state_e;

  typedef struct packed {
    logic        vld;
    logic [63:0] data;
    logic [7:0]  keep;
    logic        sof;
    logic        eof;
    logic        err;
    logic [3:0]  code;
    logic [15:0] len;
  } beat_t;

  function automatic logic [7:0] lane_mask(input logic [2:0] k);
    logic [7:0] m;
    for (int i = 0; i < 8; i++) m[i] = (i < int'(k));
    return m;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Lanes outside keep are zeroed so o_data never leaks control characters.
  function automatic beat_t mk_beat(input logic [63:0] data, input logic [7:0] keep,
                                    input logic sof, input logic eof, input logic [3:0] code,
                                    input logic [15:0] len);
    beat_t b;
    b.vld  = 1'b1;
    for (int i = 0; i < 8; i++) b.data[8*i +: 8] = keep[i] ? data[8*i +: 8] : 8'h00;
    b.keep = keep;
    b.sof  = sof;
    b.eof  = eof;
    b.err  = (code != 4'd0);
    b.code = code;
    b.len  = eof ? len : 16'd0;
    return b;
  endfunction

  // Closes the frame on the held word; with nothing held the frame had no data bytes,
  // so an empty sof+eof word is produced instead.
  function automatic beat_t close_beat(input beat_t h, input logic [3:0] code,
                                       input logic [15:0] len);
    beat_t b;
    b      = h.vld ? h : mk_beat(64'd0, 8'd0, 1'b1, 1'b1, code, len);
    b.eof  = 1'b1;
    b.err  = (code != 4'd0);
    b.code = code;
    b.len  = len;
    return b;
  endfunction

  function automatic logic [3:0] eof_code(input logic [15:0] len, input logic crc_good);
    if (len > MaxLen)      return ErrLong;
    else if (len < MinLen) return ErrRunt;
    else if (!crc_good)    return ErrCrc;
    else                   return 4'd0;
  endfunction

  // Lane decode
  logic [7:0] lane_term, lane_idle;
  logic [2:0] first_idx;
  logic       pre_ok, start_l0, ctrl_any, all_idle, first_is_term, crc_ok;

  always_comb begin
    lane_term = '0;
    lane_idle = '0;
    first_idx = '0;
    for (int i = 0; i < 8; i++) begin
      lane_term[i] = i_mii_rx_c[i] && (i_mii_rx_d[8*i +: 8] == CharTerm);
      lane_idle[i] = i_mii_rx_c[i] && (i_mii_rx_d[8*i +: 8] == CharIdle);
    end
    for (int i = 7; i >= 0; i--) begin
      if (i_mii_rx_c[i]) first_idx = 3'(i);
    end
    pre_ok = (i_mii_rx_c[7:1] == 7'd0) && (i_mii_rx_d[63:56] == SFD_CHAR);
    for (int i = 1; i < 7; i++) begin
      if (i_mii_rx_d[8*i +: 8] != PREAMBLE_CHAR) pre_ok = 1'b0;
    end
  end

  assign start_l0      = i_mii_rx_c[0] && (i_mii_rx_d[7:0] == CharStart);
  assign ctrl_any      = |i_mii_rx_c;
  assign all_idle      = &lane_idle;
  assign first_is_term = lane_term[first_idx];

  // State
  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic        sof_pend_q, sof_pend_d;
  beat_t       hold_q, hold_d;
  beat_t       out_q, out_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

`ifdef MII_RX_CRC_CHECK_EN
  logic [31:0] crc_q, crc_d, crc_word;
  logic [31:0] crc_rev;
  logic [7:0]  cur_keep;

  function automatic logic [31:0] crc_upd(input logic [31:0] crc, input logic [63:0] data,
                                          input logic [7:0] keep);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (keep[i]) begin
        c = c ^ {24'd0, data[8*i +: 8]};
        for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return c;
  endfunction

  assign cur_keep = ctrl_any ? lane_mask(first_idx) : 8'hFF;

  always_comb begin
    crc_word = crc_upd(crc_q, i_mii_rx_d, cur_keep);
    // Residue is quoted MSB-first; the register runs reflected.
    for (int i = 0; i < 32; i++) crc_rev[i] = crc_word[31-i];
  end

  assign crc_ok = (crc_rev == 32'hC704DD7B);

  always_comb begin
    crc_d = crc_q;
    if (i_valid) begin
      if (state_q == StIdle && start_l0)  crc_d = 32'hFFFFFFFF;
      else if (state_q == StData)         crc_d = crc_word;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) crc_q <= '0;
    else          crc_q <= crc_d;
  end
`else
  assign crc_ok = 1'b1;
`endif

  logic [15:0] len_full, len_part;
  logic [3:0]  close_code;

  assign len_full   = sat_add(len_q, 4'd8);
  assign len_part   = sat_add(len_q, {1'b0, first_idx});
  assign close_code = first_is_term ? eof_code(len_part, crc_ok) : ErrCtrl;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    sof_pend_d = sof_pend_q;
    hold_d     = hold_q;
    out_d      = '0;
    if (i_valid) begin
      // Every accepted word drains the hold stage into the output register.
      out_d  = hold_q;
      hold_d = '0;
      unique case (state_q)
        StIdle: begin
          if (start_l0) begin
            if (pre_ok) begin
              state_d    = StData;
              len_d      = '0;
              sof_pend_d = 1'b1;
            end else begin
              hold_d  = mk_beat(64'd0, 8'd0, 1'b1, 1'b1, ErrPreamble, 16'd0);
              state_d = StDrop;
            end
          end
        end
        StData: begin
          if (start_l0) begin
            out_d   = close_beat(hold_q, ErrStart, len_q);
            state_d = StDrop;
          end else if (!ctrl_any) begin
            len_d      = len_full;
            sof_pend_d = 1'b0;
            if (len_full > MaxLen) begin
              hold_d  = mk_beat(i_mii_rx_d, 8'hFF, sof_pend_q, 1'b1, ErrLong, len_full);
              state_d = StDrop;
            end else begin
              hold_d = mk_beat(i_mii_rx_d, 8'hFF, sof_pend_q, 1'b0, 4'd0, 16'd0);
            end
          end else begin
            // Terminate or stray control: data lanes below it close the frame.
            len_d = len_part;
            if (first_idx == 3'd0) begin
              out_d = close_beat(hold_q, close_code, len_q);
            end else begin
              hold_d = mk_beat(i_mii_rx_d, lane_mask(first_idx), sof_pend_q, 1'b1, close_code,
                               len_part);
            end
            sof_pend_d = 1'b0;
            state_d    = first_is_term ? StIdle : StDrop;
          end
        end
        StDrop: begin
          if ((|lane_term) || all_idle) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Counters follow the registered eof by one cycle.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (out_q.vld && out_q.eof) begin
      if (!out_q.err && frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + 32'd1;
      if (out_q.err && err_cnt_q != '1)    err_cnt_d   = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      len_q       <= '0;
      sof_pend_q  <= 1'b0;
      hold_q      <= '0;
      out_q       <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      sof_pend_q  <= sof_pend_d;
      hold_q      <= hold_d;
      out_q       <= out_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign o_valid     = out_q.vld;
  assign o_data      = out_q.data;
  assign o_keep      = out_q.keep;
  assign o_sof       = out_q.sof;
  assign o_eof       = out_q.eof;
  assign o_err       = out_q.err;
  assign o_err_code  = out_q.code;
  assign o_frame_len = out_q.len;
  assign o_frame_cnt = frame_cnt_q;
  assign o_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_mii_rx_checker.sv
// Directed bench for mii_rx_checker: expected output words are queued as stimulus is driven
// and compared as the DUT emits them; counters and reset state are checked inline.
module tb_mii_rx_checker;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic [63:0] i_mii_rx_d;
  logic [7:0]  i_mii_rx_c;
  logic [63:0] o_data;
  logic [7:0]  o_keep;
  logic        o_valid, o_sof, o_eof, o_err;
  logic [3:0]  o_err_code;
  logic [15:0] o_frame_len;
  logic [31:0] o_frame_cnt;
  logic [15:0] o_err_cnt;

  mii_rx_checker dut (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .i_mii_rx_d (i_mii_rx_d),
    .i_mii_rx_c (i_mii_rx_c),
    .o_data     (o_data),
    .o_keep     (o_keep),
    .o_valid    (o_valid),
    .o_sof      (o_sof),
    .o_eof      (o_eof),
    .o_err      (o_err),
    .o_err_code (o_err_code),
    .o_frame_len(o_frame_len),
    .o_frame_cnt(o_frame_cnt),
    .o_err_cnt  (o_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        sof;
    logic        eof;
    logic        err;
    logic [3:0]  code;
    logic [15:0] len;
  } exp_t;

  localparam logic [63:0] StartWord = {8'hD5, {6{8'h55}}, 8'hFB};
  localparam logic [63:0] IdleWord  = {8{8'h07}};
  localparam logic [63:0] TermWord  = {{7{8'h07}}, 8'hFD};

  exp_t sb[$];
  int   checks    = 0;
  int   failures  = 0;
  int   exp_good  = 0;
  int   exp_bad   = 0;
  bit   gap_en    = 1'b0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] data, input logic [7:0] keep, input logic sof,
                      input logic eof, input logic [3:0] code, input logic [15:0] len);
    exp_t e;
    e.data = data; e.keep = keep; e.sof = sof; e.eof = eof;
    e.err  = (code != 4'd0); e.code = code; e.len = len;
    sb.push_back(e);
    if (eof) begin
      if (code != 4'd0) exp_bad++;
      else              exp_good++;
    end
  endtask

  // One accepted word; with gap_en an ignored garbage word follows.
  task automatic send_word(input logic [63:0] d, input logic [7:0] c);
    i_mii_rx_d = d;
    i_mii_rx_c = c;
    i_valid    = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    if (gap_en) begin
      i_mii_rx_d = {$urandom, $urandom};
      i_mii_rx_c = 8'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic send_idles(input int n);
    for (int i = 0; i < n; i++) send_word(IdleWord, 8'hFF);
  endtask

  function automatic logic [3:0] frame_code(input int n);
    if (n > 1518)    return 4'd4;
    else if (n < 64) return 4'd3;
    else             return 4'd0;
  endfunction

  // Well-formed frame of n bytes ending in a terminate.
  task automatic send_frame(input int n);
    logic [7:0]  bytes[$];
    logic [63:0] w, ew;
    logic [7:0]  c, k;
    int          nfull, rem;
    for (int i = 0; i < n; i++) bytes.push_back(8'($urandom));
    nfull = n / 8;
    rem   = n % 8;
    send_word(StartWord, 8'h01);
    if (n == 0) push(64'd0, 8'd0, 1'b1, 1'b1, frame_code(0), 16'd0);
    for (int wi = 0; wi < nfull; wi++) begin
      for (int j = 0; j < 8; j++) w[8*j +: 8] = bytes[8*wi + j];
      push(w, 8'hFF, wi == 0, (rem == 0) && (wi == nfull - 1), (rem == 0 && wi == nfull - 1) ?
           frame_code(n) : 4'd0, (rem == 0 && wi == nfull - 1) ? 16'(n) : 16'd0);
      send_word(w, 8'h00);
    end
    if (rem == 0) begin
      send_word(TermWord, 8'hFF);
    end else begin
      ew = '0; k = '0; c = '0;
      for (int j = 0; j < 8; j++) begin
        if (j < rem) begin
          w[8*j +: 8] = bytes[8*nfull + j]; ew[8*j +: 8] = bytes[8*nfull + j]; k[j] = 1'b1;
        end else begin
          w[8*j +: 8] = (j == rem) ? 8'hFD : 8'h07; c[j] = 1'b1;
        end
      end
      push(ew, k, nfull == 0, 1'b1, frame_code(n), 16'(n));
      send_word(w, c);
    end
    send_idles(2);
  endtask

  task automatic check_counters(input string tag);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_good"}, 160'(o_frame_cnt), 160'(exp_good));
    check({tag, "_bad"}, 160'(o_err_cnt), 160'(exp_bad));
  endtask

  // Output monitor, away from the active edge.
  always @(negedge clk) begin
    exp_t got, e;
    if (i_rst_n === 1'b1 && o_valid === 1'b1) begin
      got = {o_data, o_keep, o_sof, o_eof, o_err, o_err_code, o_frame_len};
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $error("FAIL unexpected_word observed=%0h expected=none", got);
      end else begin
        e = sb.pop_front();
        assert (got === e) else begin
          failures++;
          $error("FAIL out_word observed=%0h expected=%0h", got, e);
        end
      end
    end
  end

  logic [63:0] w;

  initial begin
    i_rst_n    = 1'b0;
    i_valid    = 1'b0;
    i_mii_rx_d = '0;
    i_mii_rx_c = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 160'({o_valid, o_data, o_keep, o_sof, o_eof, o_err, o_err_code,
          o_frame_len, o_frame_cnt, o_err_cnt}), 160'd0);
    i_rst_n = 1'b1;
    @(posedge clk); #1;
    send_idles(2);

    send_frame(64);
    check_counters("good64");
    send_frame(67);
    check_counters("good67");

    // Bad SFD, then a good frame is accepted.
    send_word({8'hD4, {6{8'h55}}, 8'hFB}, 8'h01);
    push(64'd0, 8'd0, 1'b1, 1'b1, 4'd1, 16'd0);
    send_idles(2);
    check_counters("bad_sfd");
    send_frame(64);
    check_counters("after_bad_sfd");

    // Stray 0xFE in lane2 of the fourth data word; rest dropped until a terminate.
    send_word(StartWord, 8'h01);
    for (int i = 0; i < 3; i++) begin
      w = {$urandom, $urandom};
      push(w, 8'hFF, i == 0, 1'b0, 4'd0, 16'd0);
      send_word(w, 8'h00);
    end
    w = {$urandom, $urandom};
    push({48'd0, w[15:0]}, 8'h03, 1'b0, 1'b1, 4'd2, 16'd26);
    w[23:16] = 8'hFE;
    send_word(w, 8'h04);
    send_word({$urandom, $urandom}, 8'h00);
    send_word({$urandom, $urandom}, 8'h00);
    send_word({{2{8'h07}}, 8'hFD, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, 8'hE0);
    send_idles(2);
    check_counters("ctrl_err");

    send_frame(40);
    check_counters("runt40");
    send_frame(0);
    check_counters("empty");

    // 1600-byte stream: the word carrying byte 1519 aborts at len 1520.
    send_word(StartWord, 8'h01);
    for (int i = 0; i < 200; i++) begin
      w = {$urandom, $urandom};
      if (i < 189)       push(w, 8'hFF, i == 0, 1'b0, 4'd0, 16'd0);
      else if (i == 189) push(w, 8'hFF, 1'b0, 1'b1, 4'd4, 16'd1520);
      send_word(w, 8'h00);
    end
    send_word(TermWord, 8'hFF);
    send_idles(2);
    check_counters("too_long");

    // Restart inside a frame closes it on the held word.
    send_word(StartWord, 8'h01);
    w = {$urandom, $urandom};
    push(w, 8'hFF, 1'b1, 1'b0, 4'd0, 16'd0);
    send_word(w, 8'h00);
    w = {$urandom, $urandom};
    push(w, 8'hFF, 1'b0, 1'b1, 4'd6, 16'd16);
    send_word(w, 8'h00);
    send_word(StartWord, 8'h01);
    send_idles(2);
    check_counters("restart");

    // Same 64-byte frame with ignored words between every accepted one.
    gap_en = 1'b1;
    send_frame(64);
    check_counters("gapped64");

    // Reset in the middle of a frame.
    send_word(StartWord, 8'h01);
    w = {$urandom, $urandom};
    push(w, 8'hFF, 1'b1, 1'b0, 4'd0, 16'd0);
    send_word(w, 8'h00);
    w = {$urandom, $urandom};
    push(w, 8'hFF, 1'b0, 1'b0, 4'd0, 16'd0);
    send_word(w, 8'h00);
    send_word({$urandom, $urandom}, 8'h00);
    check("sb_before_reset", 160'(sb.size()), 160'd0);
    #2 i_rst_n = 1'b0;
    #1;
    check("midframe_reset_outputs", 160'({o_valid, o_data, o_keep, o_sof, o_eof, o_err,
          o_err_code, o_frame_len, o_frame_cnt, o_err_cnt}), 160'd0);
    exp_good = 0;
    exp_bad  = 0;
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    gap_en  = 1'b0;
    send_word({$urandom, $urandom}, 8'h00);
    send_word(TermWord, 8'hFF);
    send_idles(3);
    check_counters("after_reset");
    send_frame(64);
    check_counters("recover64");

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    check("sb_drained", 160'(sb.size()), 160'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
